// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the two-master Wishbone arbiter.
//   GNT_*              : one-hot grant encodings (2'b00 = bus idle)
//   TIMEOUT_CYCLES_DEF : default watchdog limit (8-bit counter, 1..255)
//   arb_state_e        : arbiter FSM state. The low two bits are the grant,
//                        so the state register doubles as o_grant. Bit 2
//                        marks the one-cycle ABORT state, which only exists
//                        when WB_ARB_TIMEOUT_EN is defined.
package wb_pkg;

   localparam logic [1:0] GNT_IDLE = 2'b00;
   localparam logic [1:0] GNT_M0   = 2'b01;
   localparam logic [1:0] GNT_M1   = 2'b10;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'b000,
      ST_OWN0   = 3'b001,
      ST_OWN1   = 3'b010,
      ST_ABORT0 = 3'b101,
      ST_ABORT1 = 3'b110
   } arb_state_e;

endpackage

// File: rtl/wb_arb_rr2.sv
// wb_arb_rr2: two-requester round-robin grant FSM with cycle lock.
// Optional feature macro: WB_ARB_TIMEOUT_EN (adds the ABORT states).
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_req0, i_req1 : master cyc lines (request and hold)
//   i_timeout      : watchdog fire for the current owner (ignored when
//                    the watchdog is compiled out)
//   o_grant        : one-hot owner, 2'b00 when idle (straight from the state)
//   o_abort        : high during the one-cycle ABORT state
module wb_arb_rr2
   import wb_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_req0,
   input  logic       i_req1,
   input  logic       i_timeout,
   output logic [1:0] o_grant,
   output logic       o_abort
);

   arb_state_e state_q, state_d;
   // last_owner: 1'b0 = master 0, 1'b1 = master 1. Reset to 1 so m0 wins the first tie.
   logic       last_q, last_d;
   logic       timeout_s;

`ifdef WB_ARB_TIMEOUT_EN
   assign timeout_s = i_timeout;
`else
   logic unused_timeout_s;
   assign unused_timeout_s = i_timeout;
   assign timeout_s        = 1'b0;
`endif

   // Next-state: arbitration in IDLE, lock while the owner holds cyc, direct handover on release.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (i_req0 && i_req1) begin
               state_d = last_q ? ST_OWN0 : ST_OWN1;
            end else if (i_req0) begin
               state_d = ST_OWN0;
            end else if (i_req1) begin
               state_d = ST_OWN1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_OWN0: begin
            if (!i_req0) begin
               last_d  = 1'b0;
               state_d = i_req1 ? ST_OWN1 : ST_IDLE;
            end else if (timeout_s) begin
               state_d = ST_ABORT0;
            end else begin
               state_d = ST_OWN0;
            end
         end
         ST_OWN1: begin
            if (!i_req1) begin
               last_d  = 1'b1;
               state_d = i_req0 ? ST_OWN0 : ST_IDLE;
            end else if (timeout_s) begin
               state_d = ST_ABORT1;
            end else begin
               state_d = ST_OWN1;
            end
         end
`ifdef WB_ARB_TIMEOUT_EN
         ST_ABORT0: begin
            last_d  = 1'b0;
            state_d = ST_IDLE;
         end
         ST_ABORT1: begin
            last_d  = 1'b1;
            state_d = ST_IDLE;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and last-owner registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   assign o_grant = state_q[1:0];
   assign o_abort = state_q[2];

endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master pipelined Wishbone arbiter (m0 = CPU bridge,
// m1 = debug/DMA) sharing one interconnect slave port. Round-robin with
// ownership locked for the whole cyc.
// Optional feature macro: WB_ARB_TIMEOUT_EN (watchdog + ABORT, o_timeout live).
// Ports:
//   i_clk, i_reset              : clock, synchronous active-high reset
//   i_mX_cyc/stb/we/addr/data/sel : master X request
//   o_mX_ack/stall/err/data     : master X response
//   o_s_cyc/stb/we/addr/data/sel: toward the interconnect
//   i_s_ack/stall/err/data      : from the interconnect
//   o_grant                     : one-hot owner, 2'b00 idle
//   o_timeout                   : one-cycle watchdog pulse (0 if compiled out)
module wb_arbiter_2m
   import wb_pkg::*;
#(
   parameter int unsigned AW             = 32,
   parameter int unsigned DW             = 32,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_m0_cyc,
   input  logic            i_m0_stb,
   input  logic            i_m0_we,
   input  logic [AW-1:0]   i_m0_addr,
   input  logic [DW-1:0]   i_m0_data,
   input  logic [DW/8-1:0] i_m0_sel,
   output logic            o_m0_ack,
   output logic            o_m0_stall,
   output logic            o_m0_err,
   output logic [DW-1:0]   o_m0_data,
   input  logic            i_m1_cyc,
   input  logic            i_m1_stb,
   input  logic            i_m1_we,
   input  logic [AW-1:0]   i_m1_addr,
   input  logic [DW-1:0]   i_m1_data,
   input  logic [DW/8-1:0] i_m1_sel,
   output logic            o_m1_ack,
   output logic            o_m1_stall,
   output logic            o_m1_err,
   output logic [DW-1:0]   o_m1_data,
   output logic            o_s_cyc,
   output logic            o_s_stb,
   output logic            o_s_we,
   output logic [AW-1:0]   o_s_addr,
   output logic [DW-1:0]   o_s_data,
   output logic [DW/8-1:0] o_s_sel,
   input  logic            i_s_ack,
   input  logic            i_s_stall,
   input  logic            i_s_err,
   input  logic [DW-1:0]   i_s_data,
   output logic [1:0]      o_grant,
   output logic            o_timeout
);

   logic [1:0] grant_s;
   logic       abort_s;
   logic       wd_fire_s;
   logic [2:0] route_s;

   wb_arb_rr2 u_rr2 (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_req0    (i_m0_cyc),
      .i_req1    (i_m1_cyc),
      .i_timeout (wd_fire_s),
      .o_grant   (grant_s),
      .o_abort   (abort_s)
   );

   assign o_grant = grant_s;

`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES);

   logic [7:0] wd_cnt_q, wd_cnt_d;
   logic       owner_cyc_s;

   // Owner's cyc line; the watchdog only runs while the bus is actually held.
   always_comb begin
      case (grant_s)
         GNT_M0:  owner_cyc_s = i_m0_cyc & ~abort_s;
         GNT_M1:  owner_cyc_s = i_m1_cyc & ~abort_s;
         default: owner_cyc_s = 1'b0;
      endcase
   end

   // Watchdog: clears outside OWN (so every entry starts at 0) and on any response.
   // A response in the limit cycle wins over the fire.
   always_comb begin
      wd_cnt_d  = 8'd0;
      wd_fire_s = 1'b0;
      if (owner_cyc_s) begin
         if (i_s_ack || i_s_err) begin
            wd_cnt_d = 8'd0;
         end else if (wd_cnt_q == WD_LIMIT) begin
            wd_fire_s = 1'b1;
            wd_cnt_d  = 8'd0;
         end else begin
            wd_cnt_d = wd_cnt_q + 8'd1;
         end
      end else begin
         wd_cnt_d = 8'd0;
      end
   end

   // Watchdog counter register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wd_cnt_q <= 8'd0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end

   // ABORT lasts exactly one cycle, so its decode is the timeout pulse.
   assign o_timeout = abort_s;
`else
   logic [31:0] unused_limit_s;
   assign unused_limit_s = 32'(TIMEOUT_CYCLES);
   assign wd_fire_s      = 1'b0;
   assign o_timeout      = 1'b0;
`endif

   // During reset the bus is treated as idle so no response leaks to the old owner.
   assign route_s = i_reset ? 3'b000 : {abort_s, grant_s};

   // Request mux toward the slave and response steering back to the masters.
   always_comb begin
      o_s_cyc    = 1'b0;
      o_s_stb    = 1'b0;
      o_s_we     = 1'b0;
      o_s_addr   = {AW{1'b0}};
      o_s_data   = {DW{1'b0}};
      o_s_sel    = {(DW/8){1'b0}};
      o_m0_ack   = 1'b0;
      o_m0_err   = 1'b0;
      o_m0_stall = 1'b1;
      o_m0_data  = {DW{1'b0}};
      o_m1_ack   = 1'b0;
      o_m1_err   = 1'b0;
      o_m1_stall = 1'b1;
      o_m1_data  = {DW{1'b0}};
      case (route_s)
         3'b001: begin
            o_s_cyc    = i_m0_cyc;
            o_s_stb    = i_m0_stb & i_m0_cyc;
            o_s_we     = i_m0_we;
            o_s_addr   = i_m0_addr;
            o_s_data   = i_m0_data;
            o_s_sel    = i_m0_sel;
            o_m0_ack   = i_s_ack;
            o_m0_err   = i_s_err;
            o_m0_stall = i_s_stall;
            o_m0_data  = i_s_data;
         end
         3'b010: begin
            o_s_cyc    = i_m1_cyc;
            o_s_stb    = i_m1_stb & i_m1_cyc;
            o_s_we     = i_m1_we;
            o_s_addr   = i_m1_addr;
            o_s_data   = i_m1_data;
            o_s_sel    = i_m1_sel;
            o_m1_ack   = i_s_ack;
            o_m1_err   = i_s_err;
            o_m1_stall = i_s_stall;
            o_m1_data  = i_s_data;
         end
         3'b101: begin
            o_m0_err = 1'b1;
         end
         3'b110: begin
            o_m1_err = 1'b1;
         end
         default: begin
            o_s_cyc = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed, self-checking bench for wb_arbiter_2m.
// Inputs change 2 time units after the rising edge; outputs are sampled
// 1 unit after that, well away from the next edge.
module tb_wb_arbiter_2m;

   localparam int AW = 32;
   localparam int DW = 32;

   logic            i_clk = 1'b0;
   logic            i_reset;
   logic            i_m0_cyc, i_m0_stb, i_m0_we;
   logic [AW-1:0]   i_m0_addr;
   logic [DW-1:0]   i_m0_data;
   logic [DW/8-1:0] i_m0_sel;
   logic            o_m0_ack, o_m0_stall, o_m0_err;
   logic [DW-1:0]   o_m0_data;
   logic            i_m1_cyc, i_m1_stb, i_m1_we;
   logic [AW-1:0]   i_m1_addr;
   logic [DW-1:0]   i_m1_data;
   logic [DW/8-1:0] i_m1_sel;
   logic            o_m1_ack, o_m1_stall, o_m1_err;
   logic [DW-1:0]   o_m1_data;
   logic            o_s_cyc, o_s_stb, o_s_we;
   logic [AW-1:0]   o_s_addr;
   logic [DW-1:0]   o_s_data;
   logic [DW/8-1:0] o_s_sel;
   logic            i_s_ack, i_s_stall, i_s_err;
   logic [DW-1:0]   i_s_data;
   logic [1:0]      o_grant;
   logic            o_timeout;

   int errors = 0;
   int checks = 0;

   always #5 i_clk = ~i_clk;

   wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(16)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
      .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data), .i_m0_sel(i_m0_sel),
      .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall), .o_m0_err(o_m0_err), .o_m0_data(o_m0_data),
      .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
      .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data), .i_m1_sel(i_m1_sel),
      .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall), .o_m1_err(o_m1_err), .o_m1_data(o_m1_data),
      .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
      .o_s_addr(o_s_addr), .o_s_data(o_s_data), .o_s_sel(o_s_sel),
      .i_s_ack(i_s_ack), .i_s_stall(i_s_stall), .i_s_err(i_s_err), .i_s_data(i_s_data),
      .o_grant(o_grant), .o_timeout(o_timeout)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      i_m0_cyc = 1'b0; i_m0_stb = 1'b0; i_m0_we = 1'b0;
      i_m0_addr = 32'h0; i_m0_data = 32'h0; i_m0_sel = 4'h0;
      i_m1_cyc = 1'b0; i_m1_stb = 1'b0; i_m1_we = 1'b0;
      i_m1_addr = 32'h0; i_m1_data = 32'h0; i_m1_sel = 4'h0;
      i_s_ack = 1'b0; i_s_stall = 1'b0; i_s_err = 1'b0; i_s_data = 32'h0;
   endtask

   task automatic do_reset();
      clear_inputs();
      i_reset = 1'b1;
      step();
      step();
      i_reset = 1'b0;
   endtask

   initial begin
      i_reset = 1'b1;
      clear_inputs();
      do_reset();

      // Reset state
      settle();
      chk("rst_grant", 64'(o_grant), 64'h0);
      chk("rst_s_cyc", 64'(o_s_cyc), 64'h0);
      chk("rst_s_stb", 64'(o_s_stb), 64'h0);
      chk("rst_m0_stall", 64'(o_m0_stall), 64'h1);
      chk("rst_m1_stall", 64'(o_m1_stall), 64'h1);
      chk("rst_timeout", 64'(o_timeout), 64'h0);
      chk("rst_m0_ack", 64'(o_m0_ack), 64'h0);
      chk("rst_m0_data", 64'(o_m0_data), 64'h0);

      // Single master read, ack two cycles after the request is accepted
      i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_addr = 32'h8000_0000; i_m0_sel = 4'hF;
      i_s_data = 32'hDEAD_BEEF;
      settle();
      chk("t1_req_stall", 64'(o_m0_stall), 64'h1);
      chk("t1_req_grant", 64'(o_grant), 64'h0);
      step();
      settle();
      chk("t1_grant", 64'(o_grant), 64'h1);
      chk("t1_s_cyc", 64'(o_s_cyc), 64'h1);
      chk("t1_s_stb", 64'(o_s_stb), 64'h1);
      chk("t1_s_addr", 64'(o_s_addr), 64'h8000_0000);
      chk("t1_m1_stall", 64'(o_m1_stall), 64'h1);
      step();
      i_m0_stb = 1'b0;
      settle();
      chk("t1_s_stb_low", 64'(o_s_stb), 64'h0);
      chk("t1_m1_stall_b", 64'(o_m1_stall), 64'h1);
      step();
      i_s_ack = 1'b1;
      settle();
      chk("t1_ack", 64'(o_m0_ack), 64'h1);
      chk("t1_data", 64'(o_m0_data), 64'hDEAD_BEEF);
      chk("t1_m1_ack", 64'(o_m1_ack), 64'h0);
      chk("t1_m1_data", 64'(o_m1_data), 64'h0);
      chk("t1_m1_stall_c", 64'(o_m1_stall), 64'h1);
      step();
      i_s_ack = 1'b0; i_m0_cyc = 1'b0;
      settle();
      chk("t1_drop_grant", 64'(o_grant), 64'h1);
      chk("t1_drop_s_cyc", 64'(o_s_cyc), 64'h0);
      step();
      settle();
      chk("t1_idle", 64'(o_grant), 64'h0);

      // Tie from reset: m0 first, then m1 with no idle gap
      do_reset();
      i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m1_cyc = 1'b1; i_m1_stb = 1'b1;
      i_m1_addr = 32'h0000_1234;
      step();
      settle();
      chk("t2_first", 64'(o_grant), 64'h1);
      chk("t2_m1_stall", 64'(o_m1_stall), 64'h1);
      step();
      // Owner drops cyc while an ack is still arriving: it goes to the old owner
      i_m0_cyc = 1'b0; i_m0_stb = 1'b0; i_s_ack = 1'b1;
      settle();
      chk("t2_drop_grant", 64'(o_grant), 64'h1);
      chk("t2_late_ack_m0", 64'(o_m0_ack), 64'h1);
      chk("t2_late_ack_m1", 64'(o_m1_ack), 64'h0);
      step();
      i_s_ack = 1'b0;
      settle();
      chk("t2_handover", 64'(o_grant), 64'h2);
      chk("t2_s_cyc", 64'(o_s_cyc), 64'h1);
      chk("t2_s_addr", 64'(o_s_addr), 64'h1234);
      step();
      i_m1_cyc = 1'b0; i_m1_stb = 1'b0;
      step();

      // Fairness: both request continuously; owner releases for one cycle per transaction
      do_reset();
      i_m0_cyc = 1'b1; i_m1_cyc = 1'b1;
      step();
      for (int t = 0; t < 6; t++) begin
         i_s_ack = 1'b1;
         settle();
         chk($sformatf("t3_grant_%0d", t), 64'(o_grant), (t % 2 == 0) ? 64'h1 : 64'h2);
         step();
         i_s_ack = 1'b0;
         if (t % 2 == 0) i_m0_cyc = 1'b0; else i_m1_cyc = 1'b0;
         step();
         i_m0_cyc = 1'b1; i_m1_cyc = 1'b1;
      end
      clear_inputs();
      step();

      // Lock: m1 4-beat burst, m0 requests mid-burst
      do_reset();
      i_m1_cyc = 1'b1; i_m1_stb = 1'b1;
      step();
      for (int k = 0; k < 6; k++) begin
         i_m1_stb = (k < 4) ? 1'b1 : 1'b0;
         i_s_ack  = (k >= 1 && k <= 4) ? 1'b1 : 1'b0;
         i_m1_cyc = (k < 5) ? 1'b1 : 1'b0;
         if (k == 1) i_m0_cyc = 1'b1;
         settle();
         chk($sformatf("t4_grant_%0d", k), 64'(o_grant), 64'h2);
         chk($sformatf("t4_m0_ack_%0d", k), 64'(o_m0_ack), 64'h0);
         chk($sformatf("t4_m1_ack_%0d", k), 64'(o_m1_ack), (k >= 1 && k <= 4) ? 64'h1 : 64'h0);
         step();
      end
      i_s_ack = 1'b0;
      settle();
      chk("t4_after", 64'(o_grant), 64'h1);
      clear_inputs();
      step();

      // Watchdog: slave never acks m0
      do_reset();
      i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_s_stall = 1'b1;
      step();
      settle();
      chk("t5_grant", 64'(o_grant), 64'h1);
`ifdef WB_ARB_TIMEOUT_EN
      for (int k = 1; k <= 16; k++) begin
         step();
         settle();
         chk($sformatf("t5_hold_%0d", k), 64'({o_grant, o_timeout, o_m0_err}), 64'h4);
      end
      step();
      settle();
      chk("t5_err", 64'(o_m0_err), 64'h1);
      chk("t5_ack", 64'(o_m0_ack), 64'h0);
      chk("t5_timeout", 64'(o_timeout), 64'h1);
      chk("t5_s_cyc", 64'(o_s_cyc), 64'h0);
      step();
      settle();
      chk("t5_idle", 64'(o_grant), 64'h0);
      chk("t5_pulse_end", 64'(o_timeout), 64'h0);
      clear_inputs();
      step();

      // Ack in the limit cycle wins: no abort
      do_reset();
      i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_s_stall = 1'b1;
      step();
      for (int k = 1; k <= 16; k++) step();
      i_s_ack = 1'b1;
      settle();
      step();
      i_s_ack = 1'b0;
      settle();
      chk("t5b_no_abort", 64'({o_grant, o_timeout, o_m0_err}), 64'h4);
`else
      for (int k = 1; k <= 20; k++) begin
         step();
         settle();
         chk($sformatf("t5_hold_%0d", k), 64'({o_grant, o_timeout, o_m0_err}), 64'h4);
      end
`endif
      clear_inputs();
      step();

      // Reset mid-transfer
      do_reset();
      i_m0_cyc = 1'b1; i_m0_stb = 1'b1;
      step();
      settle();
      chk("t6_grant", 64'(o_grant), 64'h1);
      i_reset = 1'b1; i_s_ack = 1'b1;
      settle();
      chk("t6_no_ack", 64'(o_m0_ack), 64'h0);
      step();
      i_reset = 1'b0; i_s_ack = 1'b0; i_m1_cyc = 1'b1;
      settle();
      chk("t6_s_cyc", 64'(o_s_cyc), 64'h0);
      chk("t6_grant_idle", 64'(o_grant), 64'h0);
      step();
      settle();
      chk("t6_tie_m0", 64'(o_grant), 64'h1);
      clear_inputs();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master Wishbone (pipelined) arbiter in front of the SoC interconnect. It shares the single interconnect slave port between master 0, the picorv32 bridge, and master 1, a debug/DMA master. Arbitration is round-robin and ownership is locked for the whole `cyc` cycle. An optional watchdog terminates hung cycles with a bus error.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width; `DW/8` select bits.
- `TIMEOUT_CYCLES`, default 255: watchdog limit; 8-bit counter, valid range 1..255.
- `i_clk`  in  1  system clock; all logic on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_m0_cyc`, `i_m0_stb`, `i_m0_we`  in  1 each  master 0 control.
- `i_m0_addr`  in  AW  master 0 address.
- `i_m0_data`  in  DW  master 0 write data.
- `i_m0_sel`  in  DW/8  master 0 byte select.
- `o_m0_ack`, `o_m0_stall`, `o_m0_err`  out  1 each  master 0 response.
- `o_m0_data`  out  DW  master 0 read data.
- `i_m1_*` / `o_m1_*`: identical set for master 1.
- `o_s_cyc`, `o_s_stb`, `o_s_we`, `o_s_addr`, `o_s_data`, `o_s_sel`  out: toward the interconnect.
- `i_s_ack`, `i_s_stall`, `i_s_err`, `i_s_data`  in: from the interconnect.
- `o_grant`  out  2  one-hot current owner; `2'b00` means idle.
- `o_timeout`  out  1  one-cycle pulse when the watchdog fires. Tied 0 when the feature is compiled out.

## Operation
- States: IDLE, OWN0, OWN1, plus ABORT when the watchdog is compiled in. The state register is `o_grant`.
- IDLE:
  - If only one `i_mX_cyc` is high, go to that master's OWN state.
  - If both are high, grant the master that did not own the bus last (`last_owner` register). After reset `last_owner=1`, so master 0 wins the first tie.
- OWNx:
  - Slave outputs mux from master x.
  - Master x receives `ack`/`err`/`data`/`stall` from the slave.
  - The other master sees `stall=1`, `ack=0`, `err=0`, `data=0`.
- Release:
  - When the owner drops `cyc`, set `last_owner=x`.
  - If the other master has `cyc` high, go directly to OWNy. Otherwise go to IDLE.
- Lock: the grant never changes while the owner holds `cyc`, whatever the other master requests.
- Gating:
  - `o_s_cyc = owner cyc`.
  - `o_s_stb = owner stb && owner cyc`.
  - In IDLE every slave output is 0.
- Master rule: a master drops `cyc` only after all of its acks or errs have returned. The arbiter does not count outstanding transfers.
- Watchdog (macro on):
  - An 8-bit counter clears on entry to OWNx and on every `i_s_ack` or `i_s_err`. It increments on every other OWN cycle.
  - When it reaches `TIMEOUT_CYCLES`, go to ABORT.
- ABORT (one cycle):
  - Owner gets `err=1`, `ack=0`; `o_s_cyc=0`; `o_timeout=1`.
  - Update `last_owner`, then go to IDLE. The next arbitration follows the IDLE rules.

## Timing
- Grant latency: `cyc` rising in IDLE at edge n gives `o_grant` valid after edge n+1. The slave sees `cyc`/`stb` in that cycle. The requester sees `stall=1` in cycle n.
- Handover: owner `cyc` low in cycle n gives the new owner on the slave port in cycle n+1. There is no dead cycle between owners.
- Response paths are combinational muxes on the registered grant. They add zero cycles to ack/err/data.
- Reset:
  - `o_grant=0`, all `o_s_*`=0, all `o_mX_ack`/`o_mX_err`/`o_mX_data`=0.
  - Both `o_mX_stall`=1.
  - `o_timeout=0`, counter=0, `last_owner=1`.
- Reset mid-cycle: the bus is dropped immediately in the next cycle. No ack or err is delivered to the old owner.
- Slave ack arriving in the same cycle the owner drops `cyc`: route it to the old owner. This is a protocol violation and is not flagged.
- Watchdog boundary: an ack in the same cycle the counter reaches the limit wins. The counter clears and no abort occurs.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined: watchdog counter and ABORT state are present; `o_timeout` is live.
- `WB_ARB_TIMEOUT_EN` undefined: no counter and no ABORT state. A hung slave holds the bus indefinitely. `o_timeout` is tied to 0.

## Structure
- Package `wb_pkg`: grant/state encodings (`GNT_IDLE=2'b00`, `GNT_M0=2'b01`, `GNT_M1=2'b10`) and the default `TIMEOUT_CYCLES` constant.
- One sub-module, `wb_arb_rr2`: the 2-requester round-robin grant FSM with lock and `last_owner`.
- The top level holds the muxes, response steering and watchdog.

## Test plan
- Single master: m0 reads `0x8000_0000` and the slave acks 2 cycles later. Expect `o_grant=01` one cycle after `cyc`, `o_m0_data=i_s_data` on the ack cycle, and m1 sees `stall=1` throughout.
- Tie from reset: both `cyc` rise together. Expect m0 granted first; m0 releases, then m1 is granted the next cycle with no idle gap.
- Fairness: both masters hold requests continuously for 6 transactions. Expect the grant to alternate 01,10,01,10,01,10.
- Lock: m1 owns the bus with a 4-beat pipelined burst while m0 requests mid-burst. Expect `o_grant` to stay 10 until m1 drops `cyc`, and m0 to receive no acks.
- Timeout (macro on, `TIMEOUT_CYCLES=16`): the slave never acks m0. Expect `o_m0_err=1` and `o_timeout=1` exactly 17 cycles after the grant, then `o_grant=00`. Macro off: `o_grant` stays 01.
- Reset mid-transfer: assert `i_reset` while m0 owns the bus with `stb` high. Next cycle expect `o_s_cyc=0` and `o_grant=00`, then m0 wins the next tie.
